// File: rtl/soc_system_gpio_pio.sv
// Parametrised Avalon-MM PIO: per-bit direction, atomic set/clear of outputs,
// two-stage input synchroniser, edge capture and a maskable level/edge interrupt.
module soc_system_gpio_pio #(
  parameter int          WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] rd_bits;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Output data register with plain, set and clear write ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_OUTSET: data_out <= data_out | wd;
        ADDR_OUTCLR: data_out <= data_out & ~wd;
        default:     data_out <= data_out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir <= DIR_RESET[WIDTH-1:0];
    end else if (wr && address == ADDR_DIR) begin
      dir <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr && address == ADDR_IRQ_MASK) begin
      irq_mask <= wd;
    end
  end

  // s1/s2 resolve metastability; s3 is the previous s2 for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    case (EDGE_TYPE)
      0:       ev = rise & ~dir;
      1:       ev = fall & ~dir;
      default: ev = (rise | fall) & ~dir;
    endcase
  end

  assign ec_clr = (wr && address == ADDR_EDGE_CAP) ? wd : '0;

  // A new event outranks a simultaneous clear so no edge is ever lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= ev | (edge_capture & ~ec_clr);
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA:     rd_bits = (dir & data_out) | (~dir & s2);
      ADDR_DIR:      rd_bits = dir;
      ADDR_IRQ_MASK: rd_bits = irq_mask;
      ADDR_EDGE_CAP: rd_bits = edge_capture;
      default:       rd_bits = '0;
    endcase
  end

  always_comb begin
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_bits;
  end

  assign out_port = data_out;
  assign oe       = dir;

  generate
    if (IRQ_TYPE == 1) begin : g_irq_edge
      assign irq = |(edge_capture & irq_mask);
    end else begin : g_irq_level
      assign irq = |(s2 & ~dir & irq_mask);
    end
  endgenerate

endmodule
